// File: rtl/inst_axi_bridge.sv
// Converts if_stage SRAM-like fetch requests into single-beat, in-order AXI reads.
// Define INST_BRIDGE_FLUSH_EN to add the flush port that discards in-flight fetches.
module inst_axi_bridge #(
  parameter int unsigned OUTSTANDING = 2,
  parameter logic [3:0]  ARID        = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
`ifdef INST_BRIDGE_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 3;

  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  discard;
  logic              flush_act;
  logic              accept;
  logic              cpl;
  logic              cpl_ok;

  // A completion with nothing outstanding is a protocol error and is ignored.
  assign cpl    = rvalid & rready & rlast;
  assign cpl_ok = cpl & (cnt_q != '0);

  assign inst_sram_addr_ok = ~reset & inst_sram_en & ~arvalid_q
                           & (cnt_q < CNT_W'(OUTSTANDING)) & (discard == '0);
  assign accept            = inst_sram_addr_ok;
  assign inst_sram_data_ok = cpl_ok & ~flush_act & (discard == '0);
  assign inst_sram_rdata   = rdata;
  assign rready            = ~reset;

  assign arid    = ARID;
  assign araddr  = araddr_q;
  assign arvalid = arvalid_q;
  assign arlen   = '0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;

  always_comb begin
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    cnt_d     = cnt_q;
    if (accept) begin
      arvalid_d = 1'b1;
      araddr_d  = inst_sram_addr;
    end else if (arvalid_q && arready) begin
      arvalid_d = 1'b0;
    end
    case ({accept, cpl_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef INST_BRIDGE_FLUSH_EN
  logic [CNT_W-1:0] discard_q, discard_d;

  // Everything in flight at flush time is dropped; a request accepted that cycle survives.
  always_comb begin
    discard_d = discard_q;
    if (flush) begin
      discard_d = cnt_q - CNT_W'(cpl_ok);
    end else if (cpl_ok && (discard_q != '0)) begin
      discard_d = discard_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      discard_q <= '0;
    end else begin
      discard_q <= discard_d;
    end
  end

  assign flush_act = flush;
  assign discard   = discard_q;
`else
  assign flush_act = 1'b0;
  assign discard   = '0;
`endif

  assert property (@(posedge clk) disable iff (reset) !(cpl && (cnt_q == '0)));
  assert property (@(posedge clk) disable iff (reset) cnt_q <= CNT_W'(OUTSTANDING));

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Scoreboard bench for inst_axi_bridge with an in-order AXI read slave model.
`timescale 1ns/1ps
module tb_inst_axi_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_sram_en = 1'b0;
  logic [31:0] inst_sram_addr = '0;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b1;
  logic [31:0] rdata = '0;
  logic        rlast = 1'b1;
  logic        rvalid = 1'b0;
  logic        rready;
`ifdef INST_BRIDGE_FLUSH_EN
  logic        flush = 1'b0;
`endif

  inst_axi_bridge #(.OUTSTANDING(2), .ARID(4'd0)) dut (
    .clk(clk), .reset(reset),
`ifdef INST_BRIDGE_FLUSH_EN
    .flush(flush),
`endif
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_ar[$];
  logic [31:0] exp_rd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave: returns ~address as the instruction word, in AR order, r_delay cycles after AR.
  logic [31:0] pend_a[$];
  int          pend_due[$];
  int          cyc = 0, r_delay = 0, ar_stall = 0, ar_cnt = 0;
  logic        ar_hs, r_hs, rst_s;
  logic [31:0] ar_a;

  always begin
    @(negedge clk);
    rst_s = reset;
    ar_hs = !reset && arvalid && arready;
    ar_a  = araddr;
    r_hs  = !reset && rvalid && rready;
    if (!reset && arvalid && !arready && ar_stall > 0) ar_stall--;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_s) begin
      pend_a.delete();
      pend_due.delete();
    end else begin
      if (r_hs && pend_a.size() > 0) begin
        void'(pend_a.pop_front());
        void'(pend_due.pop_front());
      end
      if (ar_hs) begin
        pend_a.push_back(ar_a);
        pend_due.push_back(cyc + r_delay);
        ar_cnt++;
      end
    end
    arready = (ar_stall == 0);
    if (pend_a.size() > 0 && pend_due[0] <= cyc) begin
      rvalid = 1'b1;
      rdata  = ~pend_a[0];
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
  end

  // Monitor: every AR handshake and every data_ok is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ar_unexpected: got %h expected none", araddr);
        end else begin
          check("ar_addr", araddr, exp_ar.pop_front());
        end
      end
      if (inst_sram_data_ok) begin
        if (exp_rd.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL data_unexpected: got %h expected none", inst_sram_rdata);
        end else begin
          check("rdata", inst_sram_rdata, exp_rd.pop_front());
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a request from posedge+1 and hold until accepted; leaves en asserted.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    inst_sram_en   = 1'b1;
    inst_sram_addr = a;
    @(negedge clk);
    while (!inst_sram_addr_ok && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!inst_sram_addr_ok) begin
      n_cmp++; n_bad++;
      $display("FAIL fetch_timeout: got no addr_ok required accept of %h", a);
    end else begin
      exp_ar.push_back(a);
      exp_rd.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  int ar_base;

  initial begin
    // Reset values, with a request pending to prove addr_ok is masked.
    reset = 1'b1; inst_sram_en = 1'b1; inst_sram_addr = 32'hbfc00000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
    check("rst_data_ok", 32'(inst_sram_data_ok), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; inst_sram_en = 1'b0;
    @(negedge clk);
    check("rready_on", 32'(rready), 32'd1);
    check("arid", 32'(arid), 32'd0);
    check("arsize", 32'(arsize), 32'd2);
    check("arlen", 32'(arlen), 32'd0);
    check("arburst", 32'(arburst), 32'd1);
    step(1);

    // 1: minimum latency, AR at T+1 and data at T+2.
    r_delay = 0;
    fetch(32'hbfc00000, 32'h403fffff);
    inst_sram_en = 1'b0;
    @(negedge clk);
    check("t1_arvalid", 32'(arvalid), 32'd1);
    check("t1_araddr", araddr, 32'hbfc00000);
    @(negedge clk);
    check("t1_data_ok", 32'(inst_sram_data_ok), 32'd1);
    check("t1_ar_drop", 32'(arvalid), 32'd0);
    step(3);

    // 4: accept and completion in the same cycle with one outstanding.
    r_delay = 0;
    fetch(32'hbfc00200, 32'h403ffdff);
    inst_sram_addr = 32'hbfc00204;
    @(negedge clk);
    @(negedge clk);
    check("t4_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    check("t4_data_ok", 32'(inst_sram_data_ok), 32'd1);
    if (inst_sram_addr_ok) begin
      exp_ar.push_back(32'hbfc00204);
      exp_rd.push_back(32'h403ffdfb);
    end
    @(posedge clk); #1;
    inst_sram_en = 1'b0;
    @(negedge clk);
    check("t4_new_ar", 32'(arvalid), 32'd1);
    check("t4_new_araddr", araddr, 32'hbfc00204);
    step(4);

    // 3: arready stalled three cycles.
    ar_stall = 3;
    fetch(32'hbfc00100, 32'h403ffeff);
    inst_sram_addr = 32'hbfc00104;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_arvalid", 32'(arvalid), 32'd1);
      check("t3_araddr", araddr, 32'hbfc00100);
      check("t3_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
    end
    @(negedge clk);
    check("t3_hs_cycle4", 32'(arvalid && arready), 32'd1);
    @(posedge clk); #1;
    inst_sram_en = 1'b0;
    step(4);

    // 2: two outstanding with slow R; the third request waits.
    r_delay = 5;
    ar_base = ar_cnt;
    fetch(32'hbfc00000, 32'h403fffff);
    fetch(32'hbfc00004, 32'h403ffffb);
    inst_sram_addr = 32'hbfc00008;
    @(negedge clk);
    @(negedge clk);
    check("t2_full_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
    @(posedge clk); #1;
    fetch(32'hbfc00008, 32'h403ffff7);
    check("t2_ar_count", 32'(ar_cnt - ar_base), 32'd2);
    inst_sram_en = 1'b0;
    step(15);

    // 6: reset with two outstanding and arvalid high.
    r_delay = 10;
    fetch(32'hbfc00300, 32'h403ffcff);
    fetch(32'hbfc00304, 32'h403ffcfb);
    reset = 1'b1; inst_sram_addr = 32'hbfc00308;
    exp_ar.delete();
    exp_rd.delete();
    @(negedge clk);
    check("t6_addr_ok_rst", 32'(inst_sram_addr_ok), 32'd0);
    check("t6_rready_rst", 32'(rready), 32'd0);
    @(negedge clk);
    check("t6_arvalid_cleared", 32'(arvalid), 32'd0);
    check("t6_addr_ok_next", 32'(inst_sram_addr_ok), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; inst_sram_en = 1'b0;
    step(1);
    r_delay = 3;
    fetch(32'hbfc00000, 32'h403fffff);
    fetch(32'hbfc00004, 32'h403ffffb);
    inst_sram_en = 1'b0;
    step(12);

`ifdef INST_BRIDGE_FLUSH_EN
    // 5: flush drops the two in-flight responses; the next request returns normally.
    r_delay = 8;
    fetch(32'hbfc00000, 32'h403fffff);
    fetch(32'hbfc00004, 32'h403ffffb);
    inst_sram_en = 1'b0;
    flush = 1'b1;
    exp_rd.delete();
    step(1);
    flush = 1'b0;
    inst_sram_en = 1'b1; inst_sram_addr = 32'hbfc00380;
    @(negedge clk);
    check("t5_blocked", 32'(inst_sram_addr_ok), 32'd0);
    @(posedge clk); #1;
    fetch(32'hbfc00380, 32'h403ffc7f);
    inst_sram_en = 1'b0;
    step(20);
`endif

    step(5);
    check("left_ar", 32'(exp_ar.size()), 32'd0);
    check("left_rdata", 32'(exp_rd.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
